control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Main sequencer for the multi-cycle RISC-V core. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback.
//  It drives the datapath muxes and enables, and supplies alu_op and a qualified funct7_5 to alu_decoder.
//  Memory accesses stall on a mem_ready handshake. Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored, treated as always 1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   7  instr[6:0] from IR (stable from DECODE until next FETCH)
//  funct3         in   3  instr[14:12]
//  funct7_5       in   1  instr[30]
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  memory completes the current access this cycle
//  pc_write       out  1  PC enable = pc_update | (branch & zero)
//  adr_src        out  1  0: memory address = PC; 1: memory address = ALUOut
//  mem_write      out  1  store strobe; held until mem_ready
//  ir_write       out  1  load IR and OldPC
//  reg_write      out  1  register file write
//  result_src     out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a      out  2  00 PC, 01 OldPC, 10 A (rs1)
//  alu_src_b      out  2  00 B (rs2), 01 ImmExt, 10 constant 4
//  imm_src        out  2  decoded from opcode: 00 I (lw/I-ALU), 01 S, 10 B, 11 J; 00 for R-type and unknown opcodes
//  alu_op         out  2  00 ADD, 01 SUB, 10 use funct3 (to alu_decoder)
//  alu_funct7_5   out  1  funct7_5 & (opcode==0110011 | (opcode==0010011 & funct3==101))
//  instr_done     out  1  one-cycle pulse on the final state of each instruction
//  illegal_instr  out  1  high while in ILLEGAL
//  state          out  4  current state, for debug
// BEHAVIOUR
//  Reset (rst_n=0, async): state<=FETCH. While rst_n=0, all enables (pc_write, mem_write, ir_write, reg_write) and instr_done are forced 0.
//  Outputs not listed for a state default to 0 (enables) or 00.
//  State outputs and transitions:
//   FETCH    adr_src=0, a=00, b=10, alu_op=00, result_src=10.
//            ir_write=pc_update=mem_ready. Go to DECODE on mem_ready, else stay.
//   DECODE   a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
//            0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; other -> ILLEGAL.
//   MEMADR   a=10, b=01, alu_op=00. -> MEMREAD for lw, MEMWRITE for sw.
//   MEMREAD  adr_src=1. Go to MEMWB on mem_ready, else stay.
//   MEMWRITE adr_src=1, mem_write=1. On mem_ready: instr_done=1, go to FETCH.
//   MEMWB    result_src=01, reg_write=1, instr_done=1 -> FETCH.
//   EXECR    a=10, b=00, alu_op=10 -> ALUWB.
//   EXECI    a=10, b=01, alu_op=10 -> ALUWB.
//   ALUWB    result_src=00, reg_write=1, instr_done=1 -> FETCH.
//   BEQ      a=10, b=00, alu_op=01, result_src=00, branch=1, instr_done=1 -> FETCH.
//            Taken iff zero=1 in this cycle. funct3 is not checked.
//   JAL      a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB (rd = OldPC+4).
//   ILLEGAL  illegal_instr=1, no enables. Sticky; only rst_n exits.
//  Cycle counts with mem_ready always 1: lw 5, sw 4, R/I 4, beq 3, jal 4.
//  Each cycle mem_ready stays low adds one cycle to the waiting state.
//  Memory handshake: mem_write, adr_src and the memory address stay stable across wait cycles. A mem_ready seen in a non-memory state has no effect.
//  Reset mid-instruction: the instruction is abandoned, nothing further is written, and the first fetch follows rst_n release.
// TESTING
//  1. Reset asserted during MEMWB, then released -> reg_write drops the same cycle as rst_n falls; state=FETCH; the next cycle is a fetch.
//  2. lw, mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> 10 cycles total; ir_write and reg_write each pulse exactly once.
//  3. addi with instr[30]=1 -> alu_funct7_5=0 in EXECI; srai -> 1; sub (R-type) -> 1.
//  4. beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. instr_done pulses in both cases.
//  5. jal -> pc_write in JAL, then reg_write with result_src=00 in ALUWB; imm_src=11 throughout; 4 cycles.
//  6. opcode 1110011 -> ILLEGAL; illegal_instr stays 1 for 20 cycles with all enables 0 until rst_n.

Source files
------------

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//   Main sequencer for the multi-cycle RISC-V core. A Moore FSM steps each
//   instruction through fetch, decode, execute, memory and writeback. It drives
//   the datapath muxes and enables, and gives alu_decoder the alu_op and a
//   qualified funct7_5. Memory states stall on the mem_ready handshake.
//   Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal.
//
// Parameters
//   MEM_WAIT_EN   1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: never wait
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode/funct3    instruction fields from the IR
//   funct7_5         instr[30]
//   zero             ALU zero flag (branch decision)
//   mem_ready        memory finishes the current access this cycle
//   pc_write         PC enable = pc_update | (branch & zero)
//   adr_src          memory address select (0 PC, 1 ALUOut)
//   mem_write        store strobe, held until mem_ready
//   ir_write         load IR and OldPC
//   reg_write        register file write
//   result_src       00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a        00 PC, 01 OldPC, 10 A
//   alu_src_b        00 B, 01 ImmExt, 10 constant 4
//   imm_src          immediate format decoded from opcode
//   alu_op           00 ADD, 01 SUB, 10 use funct3
//   alu_funct7_5     funct7_5 qualified for R-type and srai
//   instr_done       pulse in the last state of each instruction
//   illegal_instr    high while in ILLEGAL
//   state            current state (debug)
//
// Handshake: a memory access (FETCH, MEMREAD, MEMWRITE) completes in the cycle
// where mem_ready=1; until then the state, address select and mem_write are
// held unchanged. mem_ready in any other state is ignored.
// -----------------------------------------------------------------------------
module control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [1:0] alu_op,
    output logic       alu_funct7_5,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;
    logic   mem_rdy;
    logic   pc_update;
    logic   branch;
    logic   ir_wr_raw, reg_wr_raw, mem_wr_raw, done_raw;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // Only lw/sw reach MEMADR; opcode[5] separates store from load.
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // State-decoded outputs. Enables are AND-ed with rst_n so they drop in the
    // same cycle reset is asserted, even though state_q already reads FETCH.
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_wr_raw     = 1'b0;
        reg_wr_raw    = 1'b0;
        mem_wr_raw    = 1'b0;
        done_raw      = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_wr_raw  = mem_rdy;
                pc_update  = mem_rdy;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_wr_raw = 1'b1;
                done_raw   = mem_rdy;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_wr_raw = 1'b1;
                done_raw   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_wr_raw = 1'b1;
                done_raw   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                done_raw  = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default:   illegal_instr = 1'b1;
        endcase
    end

    assign pc_write   = rst_n & (pc_update | (branch & zero));
    assign ir_write   = rst_n & ir_wr_raw;
    assign reg_write  = rst_n & reg_wr_raw;
    assign mem_write  = rst_n & mem_wr_raw;
    assign instr_done = rst_n & done_raw;
    assign state      = state_q;

    // Immediate format straight from the opcode; R-type and unknown give I.
    always_comb begin
        unique case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // instr[30] only selects sub/sra for R-type and srai for I-type.
    assign alu_funct7_5 = funct7_5 & ((opcode == OP_R) ||
                                      ((opcode == OP_I) && (funct3 == 3'b101)));

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
  logic       alu_funct7_5, instr_done, illegal_instr;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_op(alu_op), .alu_funct7_5(alu_funct7_5), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Expected output vector {pc_write, adr_src, mem_write, ir_write, reg_write,
  // result_src, alu_src_a, alu_src_b, alu_op, instr_done, illegal_instr}.
  function automatic logic [14:0] out_model(input logic [3:0] st, input logic mr, input logic z);
    logic pcw, adr, mw, irw, rw, done, ill;
    logic [1:0] rs, a, b, op;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    rs = 0; a = 0; b = 0; op = 0;
    case (st)
      4'd0:  begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin adr = 1; mw = 1; done = mr; end
      4'd5:  begin rs = 2'b01; rw = 1; done = 1; end
      4'd6:  begin a = 2'b10; op = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd8:  begin rw = 1; done = 1; end
      4'd9:  begin a = 2'b10; op = 2'b01; done = 1; pcw = z; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: ill = 1;
    endcase
    return {pcw, adr, mw, irw, rw, rs, a, b, op, done, ill};
  endfunction

  // scoreboard: one expected cycle count per instruction, popped on instr_done
  always @(negedge clk) begin
    if (!rst_n) cyc = 0;
    else begin
      cyc++;
      if (instr_done) begin
        if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
        else check("cycles", cyc, {24'd0, exp_q.pop_front()});
        cyc = 0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_enables", {pc_write, mem_write, ir_write, reg_write, instr_done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one instruction starting in its first FETCH cycle (just after a
  // rising edge). fw/mw = mem_ready low cycles in FETCH / memory state.
  // abort >= 0 asserts reset right after the checks of that cycle.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fw, input int mw, input logic z, input int exp_cyc,
                          input logic [1:0] exp_imm, input logic exp_f7o, input int abort);
    logic [3:0] seq[$];
    int n_ir = 0, n_rw = 0, n_pc = 0, exp_rw = 0, exp_pc = 1, ms;
    logic is_mem, mr;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    for (int i = 0; i <= fw; i++) seq.push_back(4'd0);
    seq.push_back(4'd1);
    is_mem = 0;
    case (op)
      7'b0000011: begin is_mem = 1; seq.push_back(4'd2);
        for (int i = 0; i <= mw; i++) seq.push_back(4'd3);
        seq.push_back(4'd5); exp_rw = 1; end
      7'b0100011: begin is_mem = 1; seq.push_back(4'd2);
        for (int i = 0; i <= mw; i++) seq.push_back(4'd4); end
      7'b0110011: begin seq.push_back(4'd6); seq.push_back(4'd8); exp_rw = 1; end
      7'b0010011: begin seq.push_back(4'd7); seq.push_back(4'd8); exp_rw = 1; end
      7'b1100011: begin seq.push_back(4'd9); exp_pc = 1 + int'(z); end
      7'b1101111: begin seq.push_back(4'd10); seq.push_back(4'd8); exp_rw = 1; exp_pc = 2; end
      default: for (int i = 0; i < 20; i++) seq.push_back(4'd11);
    endcase
    if (exp_cyc > 0) exp_q.push_back(exp_cyc[7:0]);
    ms = fw + 3;
    for (int k = 0; k < seq.size(); k++) begin
      if (k < fw) mr = 1'b0;
      else if (k == fw) mr = 1'b1;
      else if (is_mem && k >= ms && k < ms + mw) mr = 1'b0;
      else if (is_mem && k == ms + mw) mr = 1'b1;
      else mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      @(negedge clk);
      check("state", state, seq[k]);
      check("outputs", {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                        alu_src_a, alu_src_b, alu_op, instr_done, illegal_instr},
            out_model(seq[k], mr, z));
      check("imm_src", imm_src, exp_imm);
      check("alu_funct7_5", alu_funct7_5, exp_f7o);
      n_ir += int'(ir_write); n_rw += int'(reg_write); n_pc += int'(pc_write);
      if (k == abort) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_reg_write", reg_write, 0);
        check("abort_state", state, 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    if (exp_cyc > 0) begin
      check("len", seq.size(), exp_cyc);
      check("ir_write_pulses", n_ir, 1);
      check("reg_write_pulses", n_rw, exp_rw);
      check("pc_write_pulses", n_pc, exp_pc);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    do_reset();
    //       opcode       f3      f7  fw mw z  cyc imm    f7o abort
    do_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 5,  2'b00, 0, -1); // lw
    do_instr(7'b0000011, 3'b010, 1, 3, 2, 0, 10, 2'b00, 0, -1); // lw with waits
    do_instr(7'b0100011, 3'b010, 0, 0, 0, 0, 4,  2'b01, 0, -1); // sw
    do_instr(7'b0100011, 3'b010, 1, 1, 2, 0, 7,  2'b01, 0, -1); // sw with waits
    do_instr(7'b0110011, 3'b000, 0, 0, 0, 0, 4,  2'b00, 0, -1); // add
    do_instr(7'b0110011, 3'b000, 1, 0, 0, 0, 4,  2'b00, 1, -1); // sub
    do_instr(7'b0010011, 3'b000, 1, 0, 0, 0, 4,  2'b00, 0, -1); // addi, instr[30]=1
    do_instr(7'b0010011, 3'b101, 1, 2, 0, 0, 6,  2'b00, 1, -1); // srai
    do_instr(7'b0010011, 3'b101, 0, 0, 0, 0, 4,  2'b00, 0, -1); // srli
    do_instr(7'b1100011, 3'b000, 0, 0, 0, 1, 3,  2'b10, 0, -1); // beq taken
    do_instr(7'b1100011, 3'b001, 0, 0, 0, 0, 3,  2'b10, 0, -1); // beq not taken
    do_instr(7'b1101111, 3'b000, 0, 0, 0, 0, 4,  2'b11, 0, -1); // jal
    // reset during MEMWB (cycle 4 of an lw), then a normal instruction
    do_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 5,  2'b00, 0, 4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_instr(7'b0110011, 3'b000, 0, 0, 0, 0, 4,  2'b00, 0, -1);
    // illegal opcode: sticky for 20 cycles
    do_instr(7'b1110011, 3'b000, 0, 0, 0, 0, 0,  2'b00, 0, -1);
    do_reset();
    do_instr(7'b1101111, 3'b000, 0, 1, 0, 0, 5,  2'b11, 0, -1);
    repeat (2) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
